// File: rtl/debounce_bank.sv
// Multi-channel debouncer: per-channel synchroniser plus settle counter that
// accepts a new level after SETTLE mismatching sample ticks.
module debounce_bank #(
   parameter int CHANNELS    = 4,
   parameter int CNT_W       = 4,
   parameter int SETTLE      = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                tick,
   input  logic [CHANNELS-1:0] raw_in,
   input  logic [CHANNELS-1:0] restart,
   output logic [CHANNELS-1:0] stable_out,
   output logic [CHANNELS-1:0] rise_pulse,
   output logic [CHANNELS-1:0] fall_pulse,
   output logic [CHANNELS-1:0] settled
);

   localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);
   localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

   generate
      if (SETTLE < 1 || SETTLE > (2**CNT_W) - 1) begin : g_bad_settle
         $error("debounce_bank: SETTLE must be in 1..2^CNT_W-1");
      end
      if (SYNC_STAGES < 2) begin : g_bad_sync
         $error("debounce_bank: SYNC_STAGES must be at least 2");
      end
      if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
         $error("debounce_bank: CHANNELS must be in 1..32");
      end
   endgenerate

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
         logic [SYNC_STAGES-1:0] sync_q;
         logic [CNT_W-1:0]       cnt_q, cnt_d;
         logic                   stable_q, stable_d;
         logic                   rise_q, rise_d;
         logic                   fall_q, fall_d;
         logic                   settled_q, settled_d;
         logic                   s;

         assign s = sync_q[SYNC_STAGES-1];

         // Restart beats the level comparison, which beats any tick activity.
         always_comb begin
            cnt_d     = cnt_q;
            stable_d  = stable_q;
            rise_d    = 1'b0;
            fall_d    = 1'b0;
            settled_d = settled_q;
            if (restart[gi]) begin
               cnt_d     = SETTLE_C;
               settled_d = 1'b0;
            end else if (s == stable_q) begin
               cnt_d     = SETTLE_C;
               settled_d = 1'b1;
            end else if (tick) begin
               if (cnt_q > ONE_C) begin
                  cnt_d     = cnt_q - ONE_C;
                  settled_d = 1'b0;
               end else begin
                  stable_d  = s;
                  cnt_d     = SETTLE_C;
                  settled_d = 1'b1;
                  rise_d    = s;
                  fall_d    = ~s;
               end
            end else begin
               settled_d = 1'b0;
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               sync_q    <= '0;
               cnt_q     <= SETTLE_C;
               stable_q  <= 1'b0;
               rise_q    <= 1'b0;
               fall_q    <= 1'b0;
               settled_q <= 1'b1;
            end else begin
               sync_q    <= {sync_q[SYNC_STAGES-2:0], raw_in[gi]};
               cnt_q     <= cnt_d;
               stable_q  <= stable_d;
               rise_q    <= rise_d;
               fall_q    <= fall_d;
               settled_q <= settled_d;
            end
         end

         assign stable_out[gi] = stable_q;
         assign rise_pulse[gi] = rise_q;
         assign fall_pulse[gi] = fall_q;
         assign settled[gi]    = settled_q;
      end
   endgenerate

endmodule

// File: tb/tb_debounce_bank.sv
// Randomised and directed bench for debounce_bank: a default 4-channel instance
// and a 1-channel SETTLE=1 / SYNC_STAGES=3 instance, both checked against a model.
module tb_debounce_bank;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, tick;
   logic [3:0] raw_a, rs_a;
   logic [0:0] raw_b, rs_b;
   logic [3:0] stable_a, rise_a, fall_a, settled_a;
   logic [0:0] stable_b, rise_b, fall_b, settled_b;

   debounce_bank u_dut_a (
      .clk(clk), .rst(rst), .tick(tick), .raw_in(raw_a), .restart(rs_a),
      .stable_out(stable_a), .rise_pulse(rise_a), .fall_pulse(fall_a), .settled(settled_a)
   );

   debounce_bank #(.CHANNELS(1), .CNT_W(4), .SETTLE(1), .SYNC_STAGES(3)) u_dut_b (
      .clk(clk), .rst(rst), .tick(tick), .raw_in(raw_b), .restart(rs_b),
      .stable_out(stable_b), .rise_pulse(rise_b), .fall_pulse(fall_b), .settled(settled_b)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: the synchronised value is the raw sample seen `depth`
   // edges ago; a level is accepted once `settle` mismatching ticks accumulate.
   bit m_pipe[2][4][$];
   bit m_stable[2][4];
   bit m_settled[2][4];
   bit m_rise[2][4];
   bit m_fall[2][4];
   int m_ticks[2][4];

   task automatic model_edge(input int k);
      int nch, settle, depth;
      bit s, raw, rs;
      nch    = (k == 0) ? 4 : 1;
      settle = (k == 0) ? 3 : 1;
      depth  = (k == 0) ? 2 : 3;
      for (int c = 0; c < nch; c++) begin
         raw = (k == 0) ? raw_a[c] : raw_b[0];
         rs  = (k == 0) ? rs_a[c]  : rs_b[0];
         m_rise[k][c] = 1'b0;
         m_fall[k][c] = 1'b0;
         if (rst) begin
            m_pipe[k][c].delete();
            for (int d = 0; d < depth; d++) m_pipe[k][c].push_back(1'b0);
            m_stable[k][c]  = 1'b0;
            m_ticks[k][c]   = 0;
            m_settled[k][c] = 1'b1;
         end else begin
            s = m_pipe[k][c][0];
            if (rs) begin
               m_ticks[k][c]   = 0;
               m_settled[k][c] = 1'b0;
            end else if (s == m_stable[k][c]) begin
               m_ticks[k][c]   = 0;
               m_settled[k][c] = 1'b1;
            end else if (tick) begin
               m_ticks[k][c] = m_ticks[k][c] + 1;
               if (m_ticks[k][c] == settle) begin
                  m_stable[k][c]  = s;
                  m_rise[k][c]    = s;
                  m_fall[k][c]    = !s;
                  m_ticks[k][c]   = 0;
                  m_settled[k][c] = 1'b1;
               end else begin
                  m_settled[k][c] = 1'b0;
               end
            end else begin
               m_settled[k][c] = 1'b0;
            end
            void'(m_pipe[k][c].pop_front());
            m_pipe[k][c].push_back(raw);
         end
      end
   endtask

   function automatic logic [31:0] pk(input int k, input int which);
      logic [31:0] v;
      int nch;
      v   = '0;
      nch = (k == 0) ? 4 : 1;
      for (int c = 0; c < nch; c++) begin
         case (which)
            0:       v[c] = m_stable[k][c];
            1:       v[c] = m_rise[k][c];
            2:       v[c] = m_fall[k][c];
            default: v[c] = m_settled[k][c];
         endcase
      end
      return v;
   endfunction

   task automatic check_all();
      check("stable_a",  {28'd0, stable_a},  pk(0, 0));
      check("rise_a",    {28'd0, rise_a},    pk(0, 1));
      check("fall_a",    {28'd0, fall_a},    pk(0, 2));
      check("settled_a", {28'd0, settled_a}, pk(0, 3));
      check("stable_b",  {31'd0, stable_b},  pk(1, 0));
      check("rise_b",    {31'd0, rise_b},    pk(1, 1));
      check("fall_b",    {31'd0, fall_b},    pk(1, 2));
      check("settled_b", {31'd0, settled_b}, pk(1, 3));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset(input logic [3:0] ra, input logic rb);
      rst = 1'b1; raw_a = ra; raw_b = rb; rs_a = '0; rs_b = '0; tick = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   int fall_cycle;

   initial begin
      rst = 1'b1; tick = 1'b0; raw_a = '0; raw_b = '0; rs_a = '0; rs_b = '0;
      @(negedge clk);

      // Reset with all inputs high, then release and watch the latency.
      do_reset(4'hF, 1'b1);
      check("rst_stable_a",  {28'd0, stable_a},  32'h0);
      check("rst_settled_a", {28'd0, settled_a}, 32'hF);
      check("rst_rise_a",    {28'd0, rise_a},    32'h0);
      check("rst_fall_a",    {28'd0, fall_a},    32'h0);
      for (int i = 1; i <= 6; i++) begin
         step();
         if (i == 3) check("lat_b_early", {31'd0, stable_b}, 32'h0);
         if (i == 4) begin
            check("lat_a_early", {28'd0, stable_a}, 32'h0);
            check("lat_b_edge4", {31'd0, stable_b}, 32'h1);
            check("lat_b_rise",  {31'd0, rise_b},   32'h1);
         end
         if (i == 5) begin
            check("lat_a_edge5", {28'd0, stable_a}, 32'hF);
            check("lat_a_rise",  {28'd0, rise_a},   32'hF);
            check("lat_b_rise1", {31'd0, rise_b},   32'h0);
         end
         if (i == 6) check("lat_a_rise1", {28'd0, rise_a}, 32'h0);
      end
      $display("reset/latency phase done, checks=%0d", n_checks);

      // Two-cycle glitch on ch0 must be discarded.
      do_reset(4'h0, 1'b0);
      for (int i = 0; i < 3; i++) step();
      raw_a = 4'b0001;
      step();
      step();
      raw_a = 4'b0000;
      for (int i = 0; i < 6; i++) step();
      check("glitch_stable0",  {31'd0, stable_a[0]},  32'h0);
      check("glitch_settled0", {31'd0, settled_a[0]}, 32'h1);
      $display("glitch phase done, checks=%0d", n_checks);

      // Tick every 4th cycle: fall on ch1 after the 3rd tick past the synchroniser.
      raw_a = 4'b0010; tick = 1'b1;
      for (int i = 0; i < 6; i++) step();
      check("gate_pre_stable1", {31'd0, stable_a[1]}, 32'h1);
      raw_a = 4'b0000;
      fall_cycle = -1;
      for (int i = 0; i < 24; i++) begin
         tick = (i % 4 == 3);
         step();
         if (fall_a[1] && fall_cycle < 0) fall_cycle = i;
      end
      check("gate_fall_cycle", fall_cycle, 32'd11);
      tick = 1'b1;
      $display("tick gating phase done, checks=%0d", n_checks);

      // Restart on ch2 at cnt=1 together with tick.
      do_reset(4'h0, 1'b0);
      raw_a = 4'b0100;
      for (int i = 0; i < 4; i++) step();
      rs_a = 4'b0100;
      step();
      check("rs_stable2",  {31'd0, stable_a[2]},  32'h0);
      check("rs_settled2", {31'd0, settled_a[2]}, 32'h0);
      rs_a = 4'b0000;
      step();
      step();
      check("rs_hold2", {31'd0, stable_a[2]}, 32'h0);
      step();
      check("rs_accept2", {31'd0, stable_a[2]}, 32'h1);
      check("rs_rise2",   {31'd0, rise_a[2]},   32'h1);
      $display("restart phase done, checks=%0d", n_checks);

      // Reset in the middle of a count on ch3.
      do_reset(4'h0, 1'b0);
      raw_a = 4'b1000;
      for (int i = 0; i < 3; i++) step();
      rst = 1'b1;
      step();
      check("midrst_stable",  {28'd0, stable_a},  32'h0);
      check("midrst_settled", {28'd0, settled_a}, 32'hF);
      check("midrst_fall",    {28'd0, fall_a},    32'h0);
      rst = 1'b0; raw_a = 4'b0000;
      for (int i = 0; i < 6; i++) step();
      check("midrst_after3", {31'd0, stable_a[3]}, 32'h0);
      $display("mid-count reset phase done, checks=%0d", n_checks);

      // Random soak: slowly toggling inputs, random ticks, rare restart/reset.
      for (int i = 0; i < 600; i++) begin
         for (int c = 0; c < 4; c++) begin
            if ($urandom_range(7) == 0) raw_a[c] = ~raw_a[c];
            rs_a[c] = ($urandom_range(31) == 0);
         end
         if ($urandom_range(5) == 0) raw_b[0] = ~raw_b[0];
         rs_b[0] = ($urandom_range(31) == 0);
         tick    = ($urandom_range(2) != 0);
         rst     = ($urandom_range(199) == 0);
         step();
      end
      $display("random phase done, checks=%0d", n_checks);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
